// File: rtl/pid_incremental.sv
// rtl/pid_incremental.sv - velocity-form PID controller with one time-shared multiplier
module pid_incremental #(
  parameter int DATA_W = 8,
  parameter int GAIN_W = 8,
  parameter int FRAC   = 4,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     load_gains,
  input  logic signed [GAIN_W-1:0] kp,
  input  logic signed [GAIN_W-1:0] ki,
  input  logic signed [GAIN_W-1:0] kd,
  input  logic signed [DATA_W-1:0] e_in,
  input  logic                     e_valid,
  output logic                     e_ready,
  output logic signed [DATA_W-1:0] u,
  output logic                     u_valid,
  output logic                     sat
);

  localparam int CW = GAIN_W + 2;
  localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] U_MIN = ~U_MAX;

  typedef enum logic [2:0] {IDLE, M0, M1, M2, UPD} state_t;

  state_t state, state_next;

  logic signed [CW-1:0]     a0, a1, a2;
  logic signed [CW-1:0]     a0_n, a1_n, a2_n;
  logic signed [DATA_W-1:0] e0, e1, e2, u_prev;
  logic signed [ACC_W-1:0]  acc;
  logic signed [CW-1:0]     coef_sel;
  logic signed [DATA_W-1:0] data_sel;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  v;
  logic signed [DATA_W-1:0] u_clamp;
  logic                     sat_n;
  logic                     accept;
  logic                     load_ok;

  assign e_ready = (state == IDLE);
  assign accept  = e_valid && e_ready && !clr;
  assign load_ok = load_gains && e_ready && !clr;

  assign a0_n = CW'(kp) + CW'(ki) + CW'(kd);
  assign a1_n = -(CW'(kp) + (CW'(kd) <<< 1));
  assign a2_n = CW'(kd);

  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = M0;
        M0:      state_next = M1;
        M1:      state_next = M2;
        M2:      state_next = UPD;
        UPD:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The single multiplier walks the three taps, one per compute state.
  always_comb begin
    coef_sel = '0;
    data_sel = '0;
    case (state)
      M0:      begin coef_sel = a0; data_sel = e0; end
      M1:      begin coef_sel = a1; data_sel = e1; end
      M2:      begin coef_sel = a2; data_sel = e2; end
      default: begin coef_sel = '0; data_sel = '0; end
    endcase
  end

  assign prod = ACC_W'(coef_sel) * ACC_W'(data_sel);
  assign v    = ACC_W'(u_prev) + (acc >>> FRAC);

  always_comb begin
    u_clamp = v[DATA_W-1:0];
    sat_n   = 1'b0;
    if (v > U_MAX) begin
      u_clamp = U_MAX[DATA_W-1:0];
      sat_n   = 1'b1;
    end else if (v < U_MIN) begin
      u_clamp = U_MIN[DATA_W-1:0];
      sat_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0      <= '0;
      a1      <= '0;
      a2      <= '0;
      e0      <= '0;
      e1      <= '0;
      e2      <= '0;
      u_prev  <= '0;
      acc     <= '0;
      u       <= '0;
      sat     <= 1'b0;
      u_valid <= 1'b0;
    end else if (clr) begin
      e0      <= '0;
      e1      <= '0;
      e2      <= '0;
      u_prev  <= '0;
      acc     <= '0;
      u       <= '0;
      sat     <= 1'b0;
      u_valid <= 1'b0;
    end else begin
      u_valid <= 1'b0;
      if (load_ok) begin
        a0 <= a0_n;
        a1 <= a1_n;
        a2 <= a2_n;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            e0  <= e_in;
            acc <= '0;
          end
        end
        M0, M1, M2: acc <= acc + prod;
        UPD: begin
          // Feeding back the clamped value keeps the integrator from winding up.
          u       <= u_clamp;
          u_prev  <= u_clamp;
          sat     <= sat_n;
          e2      <= e1;
          e1      <= e0;
          u_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_incremental.sv
// tb/tb_pid_incremental.sv - scoreboard bench for pid_incremental
module tb_pid_incremental;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic load_gains = 1'b0;
  logic e_valid = 1'b0;
  logic signed [7:0] kp = '0, ki = '0, kd = '0, e_in = '0;
  logic e_ready, u_valid, sat;
  logic signed [7:0] u;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int last_acc = 0;
  int prev_acc = 0;

  int q_u[$];
  int q_sat[$];
  int q_cyc[$];

  pid_incremental dut (
    .clk(clk), .rst(rst), .clr(clr), .load_gains(load_gains),
    .kp(kp), .ki(ki), .kd(kd),
    .e_in(e_in), .e_valid(e_valid), .e_ready(e_ready),
    .u(u), .u_valid(u_valid), .sat(sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    int eu, es, ec;
    if (!rst && u_valid) begin
      if (q_u.size() == 0) begin
        check("unexpected_u_valid", 1, 0);
      end else begin
        eu = q_u.pop_front();
        es = q_sat.pop_front();
        ec = q_cyc.pop_front();
        check("u", int'(u), eu);
        check("sat", int'(sat), es);
        check("latency", cyc, ec);
      end
    end
  end

  task automatic send(input int e, input bit push, input int eu, input bit es, input bit hold);
    int n = 0;
    @(negedge clk);
    e_in = 8'(e);
    e_valid = 1'b1;
    while (!e_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!e_ready) begin
      check("accept_timeout", 0, 1);
      e_valid = 1'b0;
      return;
    end
    if (push) begin
      q_u.push_back(eu);
      q_sat.push_back(int'(es));
      q_cyc.push_back(cyc + 5);
    end
    prev_acc = last_acc;
    last_acc = cyc + 1;
    @(posedge clk);
    #1;
    if (!hold) e_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q_u.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q_u.size() != 0) begin
      check("drain_timeout", q_u.size(), 0);
      q_u.delete();
      q_sat.delete();
      q_cyc.delete();
    end
  endtask

  task automatic load(input int p, input int i, input int d);
    @(negedge clk);
    kp = 8'(p);
    ki = 8'(i);
    kd = 8'(d);
    load_gains = 1'b1;
    @(negedge clk);
    load_gains = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_u", int'(u), 0);
    check("reset_sat", int'(sat), 0);
    check("reset_u_valid", int'(u_valid), 0);
    check("reset_e_ready", int'(e_ready), 1);

    // P only
    load(16, 0, 0);
    send(100, 1, 100, 0, 0);
    send(75, 1, 75, 0, 0);
    send(50, 1, 50, 0, 0);
    drain();

    // I only with saturation and anti-windup
    do_clr();
    load(0, 16, 0);
    send(10, 1, 10, 0, 0);
    send(10, 1, 20, 0, 0);
    send(10, 1, 30, 0, 0);
    send(100, 1, 127, 1, 0);
    send(-50, 1, 77, 0, 0);
    drain();

    // D only
    do_clr();
    load(0, 0, 16);
    send(0, 1, 0, 0, 0);
    send(10, 1, 10, 0, 0);
    send(10, 1, 0, 0, 0);
    send(10, 1, 0, 0, 0);
    drain();

    // floor rounding of the arithmetic shift
    do_clr();
    load(1, 0, 0);
    send(-8, 1, -1, 0, 0);
    send(8, 1, 0, 0, 0);
    drain();

    // continuous e_valid: accepts exactly 5 cycles apart
    do_clr();
    load(16, 0, 0);
    send(10, 1, 10, 0, 1);
    send(20, 1, 20, 0, 1);
    check("accept_spacing_1", last_acc - prev_acc, 5);
    send(30, 1, 30, 0, 0);
    check("accept_spacing_2", last_acc - prev_acc, 5);
    drain();

    // load_gains during M1 is ignored
    send(40, 1, 40, 0, 0);
    @(negedge clk);
    @(negedge clk);
    kp = 8'sd1;
    load_gains = 1'b1;
    check("busy_e_ready", int'(e_ready), 0);
    @(negedge clk);
    load_gains = 1'b0;
    kp = 8'sd16;
    drain();
    send(50, 1, 50, 0, 0);
    drain();

    // clr at M1 drops the sample, keeps gains
    send(60, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (6) @(negedge clk);
    check("clr_u", int'(u), 0);
    check("clr_sat", int'(sat), 0);
    check("clr_e_ready", int'(e_ready), 1);
    clr = 1'b1;
    e_in = 8'sd99;
    e_valid = 1'b1;
    @(negedge clk);
    check("clr_blocks_accept", int'(e_ready), 1);
    clr = 1'b0;
    e_valid = 1'b0;
    send(20, 1, 20, 0, 0);
    drain();

    // async reset at M2 clears everything, coefficients included
    send(30, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_u", int'(u), 0);
    check("rst_e_ready", int'(e_ready), 1);
    check("rst_u_valid", int'(u_valid), 0);
    check("rst_sat", int'(sat), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    send(50, 1, 0, 0, 0);
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
